// File: rtl/isa_pkg.sv
// ISA constants for the issue controller: opcode map, instruction field
// positions, controller state encodings and the decoded-instruction struct.
package isa_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_LW   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;
  localparam logic [3:0] OP_ADDI = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_JMP  = 4'd11;
  localparam logic [3:0] OP_HALT = 4'd12;

  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 9;
  localparam int RS_LSB  = 6;
  localparam int RT_LSB  = 3;
  localparam int SH_LSB  = 0;
  localparam int REG_W   = 3;
  localparam int CONST_W = 6;
  localparam int ADDR_W  = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_ISSUE  = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;

  typedef struct packed {
    logic [3:0]         opcode;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   shamt;
    logic [CONST_W-1:0] constant;
    logic [ADDR_W-1:0]  address;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               reserved;
    logic               reads_regs;
  } dec_t;

endpackage

// File: rtl/instr_issue_ctrl_if.sv
// Fetch (imem) and issue (datapath) bus of the issue controller.
interface instr_issue_ctrl_if;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [3:0]  opcode;
  logic [2:0]  rd;
  logic [2:0]  rs;
  logic [2:0]  rt;
  logic [2:0]  shamt;
  logic [5:0]  constant;
  logic [7:0]  address;
  logic [7:0]  pc;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        issue_valid;
  logic        issue_ready;

  modport master (
    output imem_req, imem_addr, opcode, rd, rs, rt, shamt, constant, address, pc,
           mem_read, mem_write, reg_write, issue_valid,
    input  imem_rdata, imem_valid, issue_ready
  );

  modport slave (
    input  imem_req, imem_addr, opcode, rd, rs, rt, shamt, constant, address, pc,
           mem_read, mem_write, reg_write, issue_valid,
    output imem_rdata, imem_valid, issue_ready
  );
endinterface

// File: rtl/instr_decode.sv
// Pure combinational decode of a 16-bit instruction word into fields and
// ungated control strobes.
module instr_decode
  import isa_pkg::*;
(
  input  logic [15:0] instr,
  output dec_t        dec
);

  always_comb begin
    dec          = '0;
    dec.opcode   = instr[OPC_LSB +: 4];
    dec.rd       = instr[RD_LSB +: REG_W];
    dec.rs       = instr[RS_LSB +: REG_W];
    dec.rt       = instr[RT_LSB +: REG_W];
    dec.shamt    = instr[SH_LSB +: REG_W];
    dec.constant = instr[CONST_W-1:0];
    dec.address  = instr[ADDR_W-1:0];
    case (dec.opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRL, OP_ADDI, OP_MUL: begin
        dec.reg_write  = 1'b1;
        dec.reads_regs = 1'b1;
      end
      OP_LW: begin
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
      end
      OP_SW: begin
        dec.mem_write  = 1'b1;
        dec.reads_regs = 1'b1;
      end
      OP_NOP, OP_JMP, OP_HALT: ;
      // 13..15 behave as NOP; the controller flags them at issue
      default: dec.reserved = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_issue_ctrl.sv
// Fetch/issue controller: FETCH -> WAIT -> ISSUE loop with PC, fetch timeout
// and halt handling. Define ISSUE_LOAD_USE_INTERLOCK_EN for the load-use bubble.
module instr_issue_ctrl
  import isa_pkg::*;
#(
  parameter logic [7:0] RESET_PC     = 8'h00,
  parameter int         IMEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  instr_issue_ctrl_if.master  bus,
  output logic                halted,
  output logic                illegal,
  output logic                fetch_err
);

  localparam int CW = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(IMEM_TIMEOUT - 1);

  logic [2:0]    state_q;
  logic [7:0]    pc_q;
  logic [15:0]   instr_q;
  logic [CW-1:0] wait_cnt;
  logic          fetch_err_q;
  logic          hs;
  logic          hazard;
  dec_t          dec;

  instr_decode u_dec (.instr(instr_q), .dec(dec));

  assign hs = bus.issue_valid & bus.issue_ready;

`ifdef ISSUE_LOAD_USE_INTERLOCK_EN
  logic       lw_vld_q;
  logic [2:0] lw_rd_q;
  logic       bubble_q;

  // Any handshake replaces the record, so only the immediately preceding
  // issue counts; JMP/HALT naturally clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lw_vld_q <= 1'b0;
      lw_rd_q  <= '0;
      bubble_q <= 1'b0;
    end else begin
      if (hs) begin
        lw_vld_q <= (dec.opcode == OP_LW);
        lw_rd_q  <= dec.rd;
      end
      bubble_q <= (state_q == ST_ISSUE) & ~hs;
    end
  end

  assign hazard = lw_vld_q & dec.reads_regs & ~bubble_q &
                  ((dec.rs == lw_rd_q) | (dec.rt == lw_rd_q));
`else
  logic unused_interlock;
  assign unused_interlock = dec.reads_regs;
  assign hazard = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      wait_cnt    <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          fetch_err_q <= 1'b0;
          state_q     <= ST_FETCH;
        end
        ST_FETCH: begin
          wait_cnt <= '0;
          state_q  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.imem_valid) begin
            instr_q <= bus.imem_rdata;
            state_q <= ST_ISSUE;
          end else if (wait_cnt == TMO_LAST) begin
            fetch_err_q <= 1'b1;
            state_q     <= ST_HALTED;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_ISSUE: if (hs) begin
          if (dec.opcode == OP_JMP) begin
            pc_q    <= dec.address;
            state_q <= ST_FETCH;
          end else if (dec.opcode == OP_HALT) begin
            state_q <= ST_HALTED;
          end else begin
            pc_q    <= pc_q + 8'd1;
            state_q <= ST_FETCH;
          end
        end
        ST_HALTED: if (start) begin
          pc_q        <= RESET_PC;
          fetch_err_q <= 1'b0;
          state_q     <= ST_FETCH;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.imem_req    = (state_q == ST_FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.issue_valid = (state_q == ST_ISSUE) & ~hazard;
  assign bus.opcode      = dec.opcode;
  assign bus.rd          = dec.rd;
  assign bus.rs          = dec.rs;
  assign bus.rt          = dec.rt;
  assign bus.shamt       = dec.shamt;
  assign bus.constant    = dec.constant;
  assign bus.address     = dec.address;
  // pc_q only advances at the handshake, so it names the issued word's address
  assign bus.pc          = pc_q;
  assign bus.reg_write   = dec.reg_write & bus.issue_valid;
  assign bus.mem_read    = dec.mem_read  & bus.issue_valid;
  assign bus.mem_write   = dec.mem_write & bus.issue_valid;
  assign halted          = (state_q == ST_HALTED);
  assign illegal         = hs & dec.reserved;
  assign fetch_err       = fetch_err_q;

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Directed bench for instr_issue_ctrl: memory responder, handshake monitor
// and one task per scenario with inline expected values.
module tb_instr_issue_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic halted, illegal, fetch_err;

  instr_issue_ctrl_if bus();

  instr_issue_ctrl #(.RESET_PC(8'h00), .IMEM_TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .halted(halted), .illegal(illegal), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

`ifdef ISSUE_LOAD_USE_INTERLOCK_EN
  localparam int BUB = 1;
`else
  localparam int BUB = 0;
`endif

  logic [15:0] imem [256];
  bit          mem_mute = 1'b0;
  bit          late_valid = 1'b0;
  logic        req_seen = 1'b0;
  logic [7:0]  req_addr = 8'h00;
  int          checks = 0;
  int          failures = 0;
  int          cyc_n = 0;
  int          illegal_cnt = 0;
  logic [7:0]  fetch_q [$];
  logic [3:0]  hs_op [$];
  logic [7:0]  hs_pc [$];
  int          hs_cyc [$];
  logic [2:0]  hs_str [$];

  // Memory answers during the cycle after the fetch strobe (the WAIT cycle)
  always @(negedge clk) begin
    if (mem_mute) begin
      bus.imem_valid = late_valid;
      bus.imem_rdata = 16'h7201;
    end else begin
      bus.imem_valid = req_seen;
      bus.imem_rdata = req_seen ? imem[req_addr] : 16'h0000;
    end
    req_seen = bus.imem_req;
    req_addr = bus.imem_addr;
  end

  always @(negedge clk) begin
    cyc_n++;
    if (bus.imem_req) fetch_q.push_back(bus.imem_addr);
    if (bus.issue_valid && bus.issue_ready) begin
      hs_op.push_back(bus.opcode);
      hs_pc.push_back(bus.pc);
      hs_cyc.push_back(cyc_n);
      hs_str.push_back({bus.reg_write, bus.mem_read, bus.mem_write});
    end
    if (illegal) illegal_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic clear_logs;
    fetch_q.delete(); hs_op.delete(); hs_pc.delete(); hs_cyc.delete(); hs_str.delete();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  task automatic wait_halted(input int budget, output bit ok);
    int k;
    k = 0;
    while (!halted && k < budget) begin cyc(1); k++; end
    ok = halted;
  endtask

  task automatic test_reset;
    cyc(2);
    checks++;
    if ({bus.imem_req, bus.issue_valid, halted, illegal, fetch_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 00000",
               {bus.imem_req, bus.issue_valid, halted, illegal, fetch_err});
    end
    checks++;
    if (bus.pc !== 8'h00 || bus.imem_addr !== 8'h00) begin
      failures++;
      $display("FAIL reset_pc: got pc=%h addr=%h want 00/00", bus.pc, bus.imem_addr);
    end
    checks++;
    if ({bus.opcode, bus.rd, bus.rs, bus.rt, bus.shamt, bus.constant, bus.address} !== 30'h0) begin
      failures++;
      $display("FAIL reset_fields: got %h want 0",
               {bus.opcode, bus.rd, bus.rs, bus.rt, bus.shamt, bus.constant, bus.address});
    end
    checks++;
    if ({bus.reg_write, bus.mem_read, bus.mem_write} !== 3'b000) begin
      failures++;
      $display("FAIL reset_strobes: got %b want 000", {bus.reg_write, bus.mem_read, bus.mem_write});
    end
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_lw;
    bit ok;
    clear_logs();
    imem[0] = 16'h7201;
    imem[1] = 16'hC000;
    pulse_start();
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
      failures++;
      $display("FAIL lw_fetch0: got req=%b addr=%h want 1/00", bus.imem_req, bus.imem_addr);
    end
    cyc(1);
    checks++;
    if (bus.issue_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      failures++;
      $display("FAIL lw_wait: got valid=%b req=%b want 0/0", bus.issue_valid, bus.imem_req);
    end
    cyc(1);
    checks++;
    if ({bus.issue_valid, bus.opcode, bus.address, bus.pc, bus.reg_write, bus.mem_read, bus.mem_write}
        !== {1'b1, 4'h7, 8'h01, 8'h00, 3'b110}) begin
      failures++;
      $display("FAIL lw_issue: got v=%b op=%h addr=%h pc=%h str=%b want 1/7/01/00/110",
               bus.issue_valid, bus.opcode, bus.address, bus.pc,
               {bus.reg_write, bus.mem_read, bus.mem_write});
    end
    cyc(1);
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h01) begin
      failures++;
      $display("FAIL lw_next_fetch: got req=%b addr=%h want 1/01", bus.imem_req, bus.imem_addr);
    end
    wait_halted(20, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL lw_halt: got halted=%b want 1", halted);
    end
  endtask

  task automatic test_jmp_wrap;
    bit ok;
    int k;
    clear_logs();
    imem[3]     = 16'hB0F0;
    imem[8'hF0] = 16'hB0FF;
    imem[8'hFF] = 16'h1000;
    pulse_start();
    k = 0;
    while (fetch_q.size() < 7 && k < 60) begin cyc(1); k++; end
    imem[1] = 16'hC000;
    wait_halted(40, ok);
    checks++;
    if (fetch_q.size() < 7 || !ok) begin
      failures++;
      $display("FAIL jmp_progress: got fetches=%0d halted=%b want >=7/1", fetch_q.size(), halted);
    end else begin
      checks++;
      if (fetch_q[4] !== 8'hF0) begin
        failures++;
        $display("FAIL jmp_target: got %h want f0", fetch_q[4]);
      end
      checks++;
      if (fetch_q[6] !== 8'h00 || fetch_q[5] !== 8'hFF) begin
        failures++;
        $display("FAIL pc_wrap: got %h,%h want ff,00", fetch_q[5], fetch_q[6]);
      end
      checks++;
      if (hs_op[3] !== 4'hB || hs_pc[3] !== 8'h03) begin
        failures++;
        $display("FAIL jmp_pc: got op=%h pc=%h want b/03", hs_op[3], hs_pc[3]);
      end
    end
  endtask

  task automatic test_stall;
    bit ok;
    int k, adds;
    logic [41:0] exp_v, obs_v;
    clear_logs();
    imem[0] = 16'h1253;
    imem[1] = 16'hC000;
    bus.issue_ready = 1'b0;
    pulse_start();
    k = 0;
    while (!bus.issue_valid && k < 10) begin cyc(1); k++; end
    exp_v = {1'b1, 4'h1, 3'd1, 3'd1, 3'd2, 3'd3, 6'h13, 8'h53, 8'h00, 3'b100};
    for (int i = 0; i < 5; i++) begin
      obs_v = {bus.issue_valid, bus.opcode, bus.rd, bus.rs, bus.rt, bus.shamt, bus.constant,
               bus.address, bus.pc, bus.reg_write, bus.mem_read, bus.mem_write};
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got %h want %h", i, obs_v, exp_v);
      end
      cyc(1);
    end
    checks++;
    if (hs_op.size() !== 0) begin
      failures++;
      $display("FAIL stall_no_hs: got %0d handshakes want 0", hs_op.size());
    end
    bus.issue_ready = 1'b1;
    wait_halted(20, ok);
    adds = 0;
    foreach (hs_op[i]) if (hs_op[i] == 4'h1) adds++;
    checks++;
    if (!ok || adds != 1 || hs_op.size() != 2) begin
      failures++;
      $display("FAIL stall_one_hs: got adds=%0d total=%0d halted=%b want 1/2/1",
               adds, hs_op.size(), halted);
    end
  endtask

  task automatic test_interlock;
    bit ok;
    int ill0;
    clear_logs();
    imem[0] = 16'h7401;
    imem[1] = 16'h1680;
    imem[2] = 16'hE000;
    imem[3] = 16'hC000;
    ill0 = illegal_cnt;
    pulse_start();
    wait_halted(40, ok);
    checks++;
    if (!ok || hs_op.size() != 4) begin
      failures++;
      $display("FAIL hz_progress: got hs=%0d halted=%b want 4/1", hs_op.size(), halted);
    end else begin
      checks++;
      if (hs_cyc[1] - hs_cyc[0] != 3 + BUB) begin
        failures++;
        $display("FAIL load_use_gap: got %0d want %0d", hs_cyc[1] - hs_cyc[0], 3 + BUB);
      end
      checks++;
      if (hs_cyc[2] - hs_cyc[1] != 3) begin
        failures++;
        $display("FAIL plain_gap: got %0d want 3", hs_cyc[2] - hs_cyc[1]);
      end
      checks++;
      if (hs_str[0] !== 3'b110 || hs_str[1] !== 3'b100) begin
        failures++;
        $display("FAIL hz_strobes: got %b,%b want 110,100", hs_str[0], hs_str[1]);
      end
      checks++;
      if (hs_op[2] !== 4'hE || hs_str[2] !== 3'b000) begin
        failures++;
        $display("FAIL reserved_nop: got op=%h str=%b want e/000", hs_op[2], hs_str[2]);
      end
    end
    checks++;
    if (illegal_cnt - ill0 != 1) begin
      failures++;
      $display("FAIL illegal_pulse: got %0d want 1", illegal_cnt - ill0);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    clear_logs();
    mem_mute = 1'b1;
    late_valid = 1'b0;
    pulse_start();
    cyc(15);
    checks++;
    if (halted !== 1'b0 || fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_early: got halted=%b err=%b want 0/0", halted, fetch_err);
    end
    cyc(1);
    checks++;
    if (halted !== 1'b1 || fetch_err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_expire: got halted=%b err=%b want 1/1", halted, fetch_err);
    end
    mem_mute = 1'b0;
    imem[0] = 16'hC000;
    pulse_start();
    checks++;
    if ({bus.imem_req, bus.imem_addr, fetch_err, halted} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL restart: got req=%b addr=%h err=%b halted=%b want 1/00/0/0",
               bus.imem_req, bus.imem_addr, fetch_err, halted);
    end
    wait_halted(20, ok);
    checks++;
    if (!ok || hs_op.size() != 1 || fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL halt_instr: got halted=%b hs=%0d err=%b want 1/1/0", halted, hs_op.size(), fetch_err);
    end
  endtask

  task automatic test_async_reset;
    int k;
    clear_logs();
    pulse_start();
    k = 0;
    while (fetch_q.size() < 2 && k < 20) begin cyc(1); k++; end
    mem_mute = 1'b1;
    late_valid = 1'b0;
    cyc(2);
    checks++;
    if (bus.imem_addr !== 8'h01 || bus.issue_valid !== 1'b0) begin
      failures++;
      $display("FAIL ar_setup: got addr=%h valid=%b want 01/0", bus.imem_addr, bus.issue_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.imem_req, bus.issue_valid, halted, illegal, fetch_err, bus.pc, bus.imem_addr, bus.opcode}
        !== {5'b0, 8'h00, 8'h00, 4'h0}) begin
      failures++;
      $display("FAIL async_reset: got flags=%b pc=%h addr=%h op=%h want 00000/00/00/0",
               {bus.imem_req, bus.issue_valid, halted, illegal, fetch_err},
               bus.pc, bus.imem_addr, bus.opcode);
    end
    cyc(1);
    rst_n = 1'b1;
    late_valid = 1'b1;
    cyc(3);
    checks++;
    if ({bus.issue_valid, bus.imem_req, halted, bus.opcode} !== {3'b000, 4'h0}) begin
      failures++;
      $display("FAIL late_valid: got v=%b req=%b halted=%b op=%h want 0/0/0/0",
               bus.issue_valid, bus.imem_req, halted, bus.opcode);
    end
    late_valid = 1'b0;
    mem_mute = 1'b0;
  endtask

  initial begin
    bus.issue_ready = 1'b1;
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    test_reset();
    test_lw();
    test_jmp_wrap();
    test_stall();
    test_interlock();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
